byte_ser_ctrl: RTL and testbench



---
 rtl/byte_ser_ctrl.sv | 94 +++++++++
 tb/tb_byte_ser_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/byte_ser_ctrl.sv
// Sequencer for the 4-byte serializer of the PRBS-15 datapath: walks byte_num 0..3
// rep_count times over a latched word, honouring downstream backpressure.
module byte_ser_ctrl #(
  parameter int unsigned REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      word_in,
  input  logic [REP_W-1:0] rep_count,
  input  logic             byte_ready,
  output logic [31:0]      bytes_out,
  output logic [1:0]       byte_num,
  output logic             ser_enable,
  output logic             byte_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      bytes_q, bytes_d;
  logic [1:0]       byte_num_q, byte_num_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             byte_valid_q;
  logic             ser_en;

  always_comb begin
    state_d    = state_q;
    bytes_d    = bytes_q;
    byte_num_d = byte_num_q;
    rep_cnt_d  = rep_cnt_q;
    ser_en     = (state_q == StSend) && byte_ready;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (rep_count != '0) begin
            bytes_d    = word_in;
            rep_cnt_d  = rep_count;
            byte_num_d = 2'd0;
            state_d    = StSend;
          end else begin
            // Zero-length request still reports completion, word is left untouched.
            state_d = StDone;
          end
        end
      end
      StSend: begin
        if (ser_en) begin
          byte_num_d = byte_num_q + 2'd1;
          if (byte_num_q == 2'd3) begin
            rep_cnt_d = rep_cnt_q - REP_W'(1);
            if (rep_cnt_q == REP_W'(1)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bytes_q      <= '0;
      byte_num_q   <= '0;
      rep_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_q      <= bytes_d;
      byte_num_q   <= byte_num_d;
      rep_cnt_q    <= rep_cnt_d;
      // Tracks the serializer's one-cycle registered output latency.
      byte_valid_q <= ser_en;
    end
  end

  assign bytes_out  = bytes_q;
  assign byte_num   = byte_num_q;
  assign ser_enable = ser_en;
  assign byte_valid = byte_valid_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_byte_ser_ctrl.sv
// Scoreboard bench for byte_ser_ctrl: directed transfers push expected bytes, a monitor
// pops them whenever byte_valid is high, and per-cycle timing is checked against hand values.
module tb_byte_ser_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_in = '0;
  logic [7:0]  rep_count = '0;
  logic        byte_ready = 1'b1;
  logic [31:0] bytes_out;
  logic [1:0]  byte_num;
  logic        ser_enable;
  logic        byte_valid;
  logic        busy;
  logic        done;

  byte_ser_ctrl #(.REP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_in    (word_in),
    .rep_count  (rep_count),
    .byte_ready (byte_ready),
    .bytes_out  (bytes_out),
    .byte_num   (byte_num),
    .ser_enable (ser_enable),
    .byte_valid (byte_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream serializer: registers the selected byte when enabled.
  logic [7:0] ser_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ser_q <= '0;
    else if (ser_enable) ser_q <= bytes_out[8*byte_num +: 8];
  end

  logic [7:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_total = 0;
  logic [31:0] last_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid byte must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst && byte_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h expected none at %0t", ser_q, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ser_byte", 32'(ser_q), 32'(e));
      end
    end
    if (rst && done) done_total++;
  end

  // Called on a negedge; start is sampled at the following edge (edge 0), so cycle c is
  // the interval after edge c-1. Stall cycles drop byte_ready; ign_at pulses a stray start.
  task automatic xfer(input logic [31:0] w, input logic [7:0] n,
                      input int stall_at, input int stall_len, input int ign_at);
    int  exp_done;
    bit  exp_v;
    bit  stalled_prev;
    exp_done = (n == 0) ? 1 : 4 * int'(n) + 1 + stall_len;
    for (int r = 0; r < int'(n); r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    start     = 1'b1;
    word_in   = w;
    rep_count = n;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == ign_at) begin
        start     = 1'b1;
        word_in   = 32'hFFFF_FFFF;
        rep_count = 8'd5;
      end
      stalled_prev = (c - 1 >= stall_at) && (c - 1 < stall_at + stall_len);
      exp_v = (n != 0) && (c >= 2) && (c <= exp_done) && !stalled_prev;
      chk("byte_valid", 32'(byte_valid), 32'(exp_v));
      chk("done", 32'(done), 32'(c == exp_done));
      chk("busy", 32'(busy), 32'(c <= exp_done));
      if (n == 0) chk("ser_enable_zero", 32'(ser_enable), 32'd0);
      if (stall_len > 0 && c >= stall_at && c < stall_at + stall_len)
        chk("byte_num_hold", 32'(byte_num), 32'((stall_at - 1) % 4));
      byte_ready = !((c >= stall_at) && (c < stall_at + stall_len));
    end
    byte_ready = 1'b1;
    if (n != 0) last_word = w;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("bytes_out", bytes_out, last_word);
  endtask

  initial begin
    int done_before;
    #12;
    chk("rst_bytes_out", bytes_out, 32'd0);
    chk("rst_byte_num", 32'(byte_num), 32'd0);
    chk("rst_ser_enable", 32'(ser_enable), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    xfer(32'hA1B2C3D4, 8'd1, 0, 0, 0);  // bytes D4,C3,B2,A1 in cycles 2..5
    xfer(32'h01020304, 8'd3, 0, 0, 0);  // back-to-back, 12 bytes, done in cycle 13
    xfer(32'hA1B2C3D4, 8'd1, 3, 2, 0);  // stall after second byte, done in cycle 7
    xfer(32'h0000_0000, 8'd0, 0, 0, 0); // zero count, word must not be latched
    xfer(32'h55667788, 8'd2, 0, 0, 3);  // stray start mid-transfer is ignored

    // Reset after the second byte of a 2-rep transfer.
    done_before = done_total;
    for (int b = 0; b < 8; b++) exp_q.push_back(8'(32'h11223344 >> (8 * (b % 4))));
    start     = 1'b1;
    word_in   = 32'h11223344;
    rep_count = 8'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bytes_out", bytes_out, 32'd0);
    chk("mid_rst_byte_num", 32'(byte_num), 32'd0);
    chk("mid_rst_ser_enable", 32'(ser_enable), 32'd0);
    chk("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bytes_left", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    last_word = '0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done_total), 32'(done_before));
    rst = 1'b1;

    xfer(32'hCAFEBABE, 8'd1, 0, 0, 0);
    @(negedge clk);
    chk("done_total", 32'(done_total), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
